// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: sequential shift-add multiplier, one multiplier bit per clock,
// signed/unsigned per transaction with optional early exit on an exhausted multiplier.
module seq_shift_add_mul #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  state_t               r_state, w_next;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic                 w_last, w_zero;
  assign w_abs_a = (in_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign w_abs_b = (in_signed && multiplier[WIDTH-1]) ? -multiplier : multiplier;
  assign w_last  = r_count == CW'(WIDTH-1);
  assign w_zero  = (EARLY_EXIT != 0) && (r_mplier == '0);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_RUN : S_IDLE;
      S_RUN:   w_next = (w_zero || w_last) ? S_FIX : S_RUN;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // The multiplicand is kept pre-shifted so each step adds |A| << count directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      product  <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_count  <= '0;
      r_neg    <= in_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else if (r_state == S_RUN && !w_zero) begin
      r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end else if (r_state == S_FIX) begin
      product  <= r_neg ? -r_acc : r_acc;
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign busy      = (r_state == S_RUN) || (r_state == S_FIX);
endmodule
